gate_vector_driver: RTL

//   Self-checking stimulus driver for a 4-input prefix-AND gate block (inputs a,b,c,d;

---
 rtl/gate_vector_driver.sv | 104 ++++++++++
 1 files changed

// File: rtl/gate_vector_driver.sv
`timescale 1ns/1ps
// Sweeps all 16 {a,b,c,d} vectors into a prefix-AND gate block and checks e/f/g.
// Latency: each vector is sampled SETTLE_CYCLES+1 edges after it is driven; 16*(SETTLE_CYCLES+1) per run.
// Backpressure: none; start is ignored while busy, and a held start re-launches a run from DONE.
module gate_vector_driver #(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             dut_a,
    output logic             dut_b,
    output logic             dut_c,
    output logic             dut_d,
    input  logic             dut_e,
    input  logic             dut_f,
    input  logic             dut_g,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [3:0]       first_fail_vec,
    output logic             first_fail_valid
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    state_t           state, state_nxt;
    logic [3:0]       vec;
    logic [CNT_W-1:0] settle_cnt;
    logic             exp_e, exp_f, exp_g;
    logic             mismatch;
    logic             launch;

    always_comb begin
        exp_e     = vec[3] & vec[2];
        exp_f     = exp_e & vec[1];
        exp_g     = exp_f & vec[0];
        // One failed vector counts once no matter how many outputs are wrong.
        mismatch  = (dut_e != exp_e) | (dut_f != exp_f) | (dut_g != exp_g);
        launch    = 1'b0;
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    launch    = 1'b1;
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt == CNT_W'(1)) state_nxt = SAMPLE;
            end
            SAMPLE: begin
                state_nxt = (vec == 4'hF) ? DONE : SETTLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            vec              <= 4'd0;
            settle_cnt       <= '0;
            err_cnt          <= '0;
            first_fail_vec   <= 4'd0;
            first_fail_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            if (launch) begin
                vec              <= 4'd0;
                settle_cnt       <= CNT_W'(SETTLE_CYCLES);
                err_cnt          <= '0;
                first_fail_vec   <= 4'd0;
                first_fail_valid <= 1'b0;
            end else if (state == SETTLE) begin
                settle_cnt <= settle_cnt - CNT_W'(1);
            end else if (state == SAMPLE) begin
                if (mismatch) begin
                    if (err_cnt != ERR_MAX) err_cnt <= err_cnt + ERR_W'(1);
                    if (!first_fail_valid) begin
                        first_fail_vec   <= vec;
                        first_fail_valid <= 1'b1;
                    end
                end
                if (vec != 4'hF) begin
                    vec        <= vec + 4'd1;
                    settle_cnt <= CNT_W'(SETTLE_CYCLES);
                end
            end
        end
    end

    // The DUT drive is the vec register itself, so it only moves on the edge that loads vec.
    assign {dut_a, dut_b, dut_c, dut_d} = vec;
    assign busy = (state == SETTLE) || (state == SAMPLE);
    assign done = (state == DONE);
    assign pass = done && (err_cnt == '0);

endmodule
